// File: rtl/piece_sequencer_pkg.sv
// rtl/piece_sequencer_pkg.sv - piece codes, LFSR constants and bag helpers for the piece sequencer
package piece_sequencer_pkg;

  localparam logic [2:0] PIECE_I    = 3'd0;
  localparam logic [2:0] PIECE_J    = 3'd1;
  localparam logic [2:0] PIECE_L    = 3'd2;
  localparam logic [2:0] PIECE_O    = 3'd3;
  localparam logic [2:0] PIECE_S    = 3'd4;
  localparam logic [2:0] PIECE_T    = 3'd5;
  localparam logic [2:0] PIECE_Z    = 3'd6;
  localparam logic [2:0] PIECE_NONE = 3'd7;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic {
    ST_DRAW  = 1'b0,
    ST_READY = 1'b1
  } seq_state_t;

  // Three LFSR bits give 0..7; the out-of-range 7 folds onto the first piece.
  function automatic logic [2:0] cand_from_lfsr(input logic [2:0] bits);
    return (bits == PIECE_NONE) ? PIECE_I : bits;
  endfunction

  function automatic logic [2:0] cand_advance(input logic [2:0] c);
    return (c == PIECE_Z) ? PIECE_I : c + 3'd1;
  endfunction

  function automatic logic [2:0] bag_free(input logic [6:0] b);
    logic [2:0] used;
    used = 3'd0;
    for (int i = 0; i < 7; i++) begin
      used = used + {2'b00, b[i]};
    end
    return 3'd7 - used;
  endfunction

endpackage

// File: rtl/piece_lfsr.sv
// rtl/piece_lfsr.sv - free-running 16-bit Galois LFSR, never allowed to start at zero
module piece_lfsr
  import piece_sequencer_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED_EFF;
    end else begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0000);
    end
  end

endmodule

// File: rtl/piece_sequencer.sv
// rtl/piece_sequencer.sv - 7-bag piece randomizer with current/preview pieces and spawn handshake
module piece_sequencer
  import piece_sequencer_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic       spawn_req,
  output logic       spawn_ack,
  output logic [2:0] cur_piece,
  output logic [2:0] next_piece,
  output logic       ready,
  output logic [2:0] bag_remaining
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
  localparam logic [2:0]  RST_CAND = cand_from_lfsr(SEED_EFF[2:0]);

  logic [15:0] lfsr_q;
  logic        lfsr_unused;

  seq_state_t state, state_n;
  logic [1:0] fills_left, fills_n;
  logic [6:0] bag, bag_n, sel_bag, cand_bit;
  logic [2:0] cand, cand_n;
  logic [2:0] cur_n, next_n, rem_n;
  logic       ack_n, ready_n;

  piece_lfsr #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[15:3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_DRAW;
      fills_left    <= 2'd2;
      bag           <= 7'h00;
      cand          <= RST_CAND;
      cur_piece     <= PIECE_NONE;
      next_piece    <= PIECE_NONE;
      spawn_ack     <= 1'b0;
      ready         <= 1'b0;
      bag_remaining <= 3'd7;
    end else begin
      state         <= state_n;
      fills_left    <= fills_n;
      bag           <= bag_n;
      cand          <= cand_n;
      cur_piece     <= cur_n;
      next_piece    <= next_n;
      spawn_ack     <= ack_n;
      ready         <= ready_n;
      bag_remaining <= rem_n;
    end
  end

  always_comb begin
    state_n  = state;
    fills_n  = fills_left;
    bag_n    = bag;
    cand_n   = cand;
    cur_n    = cur_piece;
    next_n   = next_piece;
    ack_n    = 1'b0;
    cand_bit = 7'd1 << cand;
    sel_bag  = bag | cand_bit;

    if (restart) begin
      state_n = ST_DRAW;
      fills_n = 2'd2;
      bag_n   = 7'h00;
      cand_n  = cand_from_lfsr(lfsr_q[2:0]);
      cur_n   = PIECE_NONE;
      next_n  = PIECE_NONE;
    end else begin
      case (state)
        ST_DRAW: begin
          if ((bag & cand_bit) == 7'h00) begin
            cur_n   = next_piece;
            next_n  = cand;
            // A full bag is emptied on the very edge that completes it.
            bag_n   = (sel_bag == 7'h7F) ? 7'h00 : sel_bag;
            fills_n = fills_left - 2'd1;
            if (fills_left == 2'd1) begin
              state_n = ST_READY;
              ack_n   = 1'b1;
            end else begin
              cand_n = cand_from_lfsr(lfsr_q[2:0]);
            end
          end else begin
            cand_n = cand_advance(cand);
          end
        end
        ST_READY: begin
          // A request still high during the ack cycle is the one just served.
          if (spawn_req && !spawn_ack) begin
            state_n = ST_DRAW;
            fills_n = 2'd1;
            cand_n  = cand_from_lfsr(lfsr_q[2:0]);
          end
        end
        default: state_n = ST_DRAW;
      endcase
    end

    ready_n = (state_n == ST_READY);
    rem_n   = bag_free(bag_n);
  end

endmodule

// File: tb/tb_piece_sequencer.sv
// tb/tb_piece_sequencer.sv - randomized self-checking bench for piece_sequencer against a draw-level model
module tb_piece_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       restart = 1'b0;
  logic       spawn_req = 1'b0;
  logic       ack, ready;
  logic [2:0] cur, nxt, rem;
  logic       z_ack, z_ready;
  logic [2:0] z_cur, z_nxt, z_rem;

  piece_sequencer #(.SEED(16'hACE1)) dut (
    .clk           (clk),
    .rst           (rst),
    .restart       (restart),
    .spawn_req     (spawn_req),
    .spawn_ack     (ack),
    .cur_piece     (cur),
    .next_piece    (nxt),
    .ready         (ready),
    .bag_remaining (rem)
  );

  piece_sequencer #(.SEED(16'h0000)) dut_z (
    .clk           (clk),
    .rst           (rst),
    .restart       (restart),
    .spawn_req     (spawn_req),
    .spawn_ack     (z_ack),
    .cur_piece     (z_cur),
    .next_piece    (z_nxt),
    .ready         (z_ready),
    .bag_remaining (z_rem)
  );

  always #5 clk = ~clk;

  int edge_n;
  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  int cur_m, next_m, last_s;
  bit used [7];
  int obs [$];

  // LFSR value sampled at edge e after reset release (edge 1 sees the seed).
  function automatic logic [15:0] lfsr_at(input int e);
    logic [15:0] v = 16'hACE1;
    for (int i = 1; i < e; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    return v;
  endfunction

  function automatic int to_cand(input logic [15:0] v);
    int c = int'(v[2:0]);
    return (c == 7) ? 0 : c;
  endfunction

  function automatic int used_count();
    int n = 0;
    foreach (used[i]) n += int'(used[i]);
    return n;
  endfunction

  task automatic model_reset();
    cur_m = 7;
    next_m = 7;
    foreach (used[i]) used[i] = 1'b0;
    obs.delete();
  endtask

  // Each fill picks the first unused piece cyclically from the candidate; every skipped piece costs a cycle.
  task automatic model_fill(input int load_e, input int eval_e, input int fills, output int sel_e);
    int c = to_cand(lfsr_at(load_e));
    int e = eval_e;
    sel_e = e;
    for (int f = 0; f < fills; f++) begin
      int d = 0;
      int p;
      while (used[(c + d) % 7] && d < 7) d++;
      p = (c + d) % 7;
      sel_e = e + d;
      cur_m = next_m;
      next_m = p;
      used[p] = 1'b1;
      if (used_count() == 7) foreach (used[i]) used[i] = 1'b0;
      if (f < fills - 1) begin
        c = to_cand(lfsr_at(sel_e));
        e = sel_e + 1;
      end
    end
  endtask

  task automatic note_draw(input int p);
    obs.push_back(p);
    if (obs.size() % 7 == 0) begin
      int mask = 0;
      for (int i = obs.size() - 7; i < obs.size(); i++) mask |= (1 << obs[i]);
      check("bag_window_perm", mask, 127);
    end
  endtask

  task automatic wait_ack(input int exp_e, input int acc_e);
    bit got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (ack) got = 1'b1;
      else if (edge_n >= acc_e) check("ready_low_in_draw", int'(ready), 0);
    end
    check("ack_seen", int'(got), 1);
    check("ack_edge", edge_n, exp_e);
    check("cur_piece", int'(cur), cur_m);
    check("next_piece", int'(nxt), next_m);
    check("ready_with_ack", int'(ready), 1);
    check("bag_remaining", int'(rem), 7 - used_count());
    check("seed0_ack", int'(z_ack), 1);
    check("seed0_cur", int'(z_cur), cur_m);
    check("seed0_next", int'(z_nxt), next_m);
    check("seed0_rem", int'(z_rem), 7 - used_count());
  endtask

  task automatic spawn(input bit hold);
    int k, s, prev_next;
    if (hold) begin
      spawn_req = 1'b1;
      @(negedge clk);
      check("ack_single_cycle", int'(ack), 0);
      k = last_s + 2;
    end else begin
      spawn_req = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      spawn_req = 1'b1;
      k = (edge_n + 1 > last_s + 2) ? edge_n + 1 : last_s + 2;
    end
    prev_next = next_m;
    model_fill(k, k + 1, 1, s);
    wait_ack(s, k);
    check("cur_is_prev_next", int'(cur), prev_next);
    note_draw(int'(nxt));
    last_s = s;
    if (!hold) spawn_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cur"}, int'(cur), 7);
    check({tag, "_next"}, int'(nxt), 7);
    check({tag, "_ack"}, int'(ack), 0);
    check({tag, "_ready"}, int'(ready), 0);
    check({tag, "_rem"}, int'(rem), 7);
  endtask

  task automatic init_fill();
    int s;
    model_reset();
    model_fill(1, 1, 2, s);
    wait_ack(s, 0);
    check("init_within_14", int'(edge_n <= 14), 1);
    check("init_distinct", int'(cur != nxt), 1);
    note_draw(int'(cur));
    note_draw(int'(nxt));
    last_s = s;
  endtask

  initial begin
    int s, k;
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    init_fill();

    repeat (70) spawn(1'b0);
    repeat (20) spawn(1'b1);

    // Restart during the first DRAW cycle after an accepted request.
    spawn_req = 1'b1;
    k = last_s + 2;
    while (edge_n < k) @(negedge clk);
    restart = 1'b1;
    spawn_req = 1'b0;
    @(negedge clk);
    restart = 1'b0;
    check_reset_outputs("restart");
    model_reset();
    model_fill(edge_n, edge_n + 1, 2, s);
    wait_ack(s, edge_n);
    note_draw(int'(cur));
    note_draw(int'(nxt));
    last_s = s;
    repeat (5) spawn(1'b0);

    // Asynchronous reset between edges while drawing.
    spawn_req = 1'b1;
    k = last_s + 2;
    while (edge_n < k) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    spawn_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    init_fill();
    repeat (5) spawn(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
